mem_stage: RTL and testbench

- Memory and writeback stage of the 5-stage RV32 pipeline.
- Consumes the M-stage register outputs (ALUResultM, WriteDataM, MemWriteM, ResultSrcM, RegWriteM, RdM, PCPlus4M).
- Performs word loads/stores over a valid/ready data-memory bus, stalling the pipeline while the access is outstanding.
- Owns the W-stage register that produces ResultW, RdW and RegWriteW for the register file and the forwarding muxes.

---
 rtl/mem_stage.sv | 238 +++++++++++++++++++++++
 tb/tb_mem_stage.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// mem_stage: memory + writeback stage of the 5-stage RV32 pipeline.
//
// Takes the M-stage register outputs, performs one word load or store at a
// time over a valid/ready data-memory bus, stalls the front of the pipeline
// while that access is outstanding, and owns the W-stage register that feeds
// the register file and the forwarding muxes.
//
// Optional build macro: MEM_STAGE_ALIGN_CHECK_EN
//   defined   : a memop whose address has ALUResultM[1:0] != 2'b00 issues no
//               bus request; it goes straight to DONE, is dropped at
//               writeback (RegWriteW=0), and pulses MisalignW for one cycle.
//   undefined : the low two address bits are dropped (the access goes to the
//               aligned word) and MisalignW is tied low.
//
// Bus handshake: the request payload (req_we, req_addr, req_wdata) is held
// stable from the cycle req_valid rises until the cycle in which req_valid
// and req_ready are both high, and that cycle transfers the request.
// req_ready while req_valid is low has no effect. A load's data is taken
// from the first cycle with resp_valid high after its request transferred;
// resp_valid is ignored at every other time. At most one request is
// outstanding. A reset abandons any access in flight, and a response
// arriving after that reset is discarded.
//
// The FSM state is visible on dbg_state_o (IDLE=0, REQ=1, RESP=2, DONE=3).

module mem_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  // M-stage register outputs
  input  logic [XLEN-1:0] ALUResultM,
  input  logic [XLEN-1:0] WriteDataM,
  input  logic            MemWriteM,
  input  logic [1:0]      ResultSrcM,
  input  logic            RegWriteM,
  input  logic [4:0]      RdM,
  input  logic [XLEN-1:0] PCPlus4M,
  // stall to the hazard unit
  output logic            StallM,
  // data-memory bus
  output logic            req_valid,
  output logic            req_we,
  output logic [XLEN-1:0] req_addr,
  output logic [XLEN-1:0] req_wdata,
  input  logic            req_ready,
  input  logic            resp_valid,
  input  logic [XLEN-1:0] resp_rdata,
  // W-stage register outputs
  output logic [XLEN-1:0] ResultW,
  output logic [4:0]      RdW,
  output logic            RegWriteW,
  output logic            MisalignW,
  // debug view of the access FSM
  output logic [1:0]      dbg_state_o
);

  // ResultSrcM encodings
  localparam logic [1:0] SRC_ALU  = 2'b00;
  localparam logic [1:0] SRC_LOAD = 2'b01;
  localparam logic [1:0] SRC_PC4  = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2,
    DONE = 2'd3
  } state_e;

  state_e          state_q, state_d;

  // request payload registers, loaded once per access in IDLE
  logic            req_we_q, req_we_d;
  logic [XLEN-1:0] req_addr_q, req_addr_d;
  logic [XLEN-1:0] req_wdata_q, req_wdata_d;

  // load buffer: holds the returned word until the op leaves M
  logic [XLEN-1:0] load_buf_q, load_buf_d;

  // W-stage register
  logic [XLEN-1:0] result_w_q, result_w_d;
  logic [4:0]      rd_w_q, rd_w_d;
  logic            regwrite_w_q, regwrite_w_d;

  logic            memop;
  logic            mis_done;   // misaligned op is leaving M this cycle

  // an op needs the bus when it stores or loads
  assign memop = MemWriteM | (ResultSrcM == SRC_LOAD);

  // hold F/D/E/M until the access reaches DONE; non-mem ops never stall
  assign StallM = memop & (state_q != DONE);

`ifdef MEM_STAGE_ALIGN_CHECK_EN
  // flags that the access being processed had a misaligned address
  logic            mis_q, mis_d;
  logic            misalign_w_q, misalign_w_d;

  assign mis_done = (state_q == DONE) & mis_q;
`else
  assign mis_done = 1'b0;
`endif

  // access FSM: next state, request payload capture and load-buffer capture
  always_comb begin
    state_d     = state_q;
    req_we_d    = req_we_q;
    req_addr_d  = req_addr_q;
    req_wdata_d = req_wdata_q;
    load_buf_d  = load_buf_q;
`ifdef MEM_STAGE_ALIGN_CHECK_EN
    mis_d       = mis_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (memop) begin
          req_addr_d  = {ALUResultM[XLEN-1:2], 2'b00};
          req_wdata_d = WriteDataM;
          req_we_d    = MemWriteM;
`ifdef MEM_STAGE_ALIGN_CHECK_EN
          mis_d       = (ALUResultM[1:0] != 2'b00);
          state_d     = (ALUResultM[1:0] != 2'b00) ? DONE : REQ;
`else
          state_d     = REQ;
`endif
        end
      end
      REQ: begin
        if (req_ready) begin
          state_d = req_we_q ? DONE : RESP;
        end
      end
      RESP: begin
        if (resp_valid) begin
          load_buf_d = resp_rdata;
          state_d    = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // access FSM state and request/load registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      req_we_q    <= 1'b0;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      load_buf_q  <= '0;
`ifdef MEM_STAGE_ALIGN_CHECK_EN
      mis_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      req_we_q    <= req_we_d;
      req_addr_q  <= req_addr_d;
      req_wdata_q <= req_wdata_d;
      load_buf_q  <= load_buf_d;
`ifdef MEM_STAGE_ALIGN_CHECK_EN
      mis_q       <= mis_d;
`endif
    end
  end

  // W-stage next value: bubble while stalled, otherwise select the result
  always_comb begin
    result_w_d   = result_w_q;
    rd_w_d       = rd_w_q;
    regwrite_w_d = 1'b0;
    if (!StallM) begin
      rd_w_d       = RdM;
      regwrite_w_d = RegWriteM & ~mis_done;
      case (ResultSrcM)
        SRC_LOAD: result_w_d = load_buf_q;
        SRC_PC4:  result_w_d = PCPlus4M;
        default:  result_w_d = ALUResultM;   // SRC_ALU and reserved 2'b11
      endcase
    end
  end

`ifdef MEM_STAGE_ALIGN_CHECK_EN
  // one-cycle misalign pulse on the edge a misaligned op leaves M
  always_comb begin
    misalign_w_d = ~StallM & mis_done;
  end
`endif

  // W-stage register
  always_ff @(posedge clk) begin
    if (reset) begin
      result_w_q   <= '0;
      rd_w_q       <= '0;
      regwrite_w_q <= 1'b0;
`ifdef MEM_STAGE_ALIGN_CHECK_EN
      misalign_w_q <= 1'b0;
`endif
    end else begin
      result_w_q   <= result_w_d;
      rd_w_q       <= rd_w_d;
      regwrite_w_q <= regwrite_w_d;
`ifdef MEM_STAGE_ALIGN_CHECK_EN
      misalign_w_q <= misalign_w_d;
`endif
    end
  end

  assign req_valid   = (state_q == REQ);
  assign req_we      = req_we_q;
  assign req_addr    = req_addr_q;
  assign req_wdata   = req_wdata_q;

  assign ResultW     = result_w_q;
  assign RdW         = rd_w_q;
  assign RegWriteW   = regwrite_w_q;
`ifdef MEM_STAGE_ALIGN_CHECK_EN
  assign MisalignW   = misalign_w_q;
`else
  assign MisalignW   = 1'b0;
`endif

  assign dbg_state_o = state_q;

  // payload must stay put while a request waits for ready
  a_req_stable: assert property (@(posedge clk) disable iff (reset)
    (req_valid && !req_ready) |=>
      (req_valid && $stable(req_addr) && $stable(req_wdata) && $stable(req_we)));

  // DONE always lasts exactly one cycle
  a_done_one_cycle: assert property (@(posedge clk) disable iff (reset)
    (state_q == DONE) |=> (state_q == IDLE));

endmodule

// File: tb/tb_mem_stage.sv
// Testbench for mem_stage: scenario tasks with inline checks against a
// timing/result model derived from the stage's documented behaviour.
// Build with +define+MEM_STAGE_ALIGN_CHECK_EN to exercise the alignment check.
module tb_mem_stage;

  localparam int XLEN = 32;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RESP = 2'd2;

`ifdef MEM_STAGE_ALIGN_CHECK_EN
  localparam bit ALIGN_EN = 1'b1;
`else
  localparam bit ALIGN_EN = 1'b0;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic            clk;
  logic            reset;
  logic [XLEN-1:0] ALUResultM, WriteDataM, PCPlus4M;
  logic            MemWriteM, RegWriteM;
  logic [1:0]      ResultSrcM;
  logic [4:0]      RdM;
  logic            StallM;
  logic            req_valid, req_we, req_ready, resp_valid;
  logic [XLEN-1:0] req_addr, req_wdata, resp_rdata;
  logic [XLEN-1:0] ResultW;
  logic [4:0]      RdW;
  logic            RegWriteW, MisalignW;
  logic [1:0]      dbg_state;

  int assert_cnt = 0;
  int fail_cnt   = 0;

  // scoreboard: expected writeback value of each memop, in issue order
  logic [XLEN-1:0] exp_q[$];

  mem_stage #(.XLEN(XLEN)) dut (
    .clk(clk), .reset(reset),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .MemWriteM(MemWriteM),
    .ResultSrcM(ResultSrcM), .RegWriteM(RegWriteM), .RdM(RdM), .PCPlus4M(PCPlus4M),
    .StallM(StallM),
    .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .ResultW(ResultW), .RdW(RdW), .RegWriteW(RegWriteW), .MisalignW(MisalignW),
    .dbg_state_o(dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic drive_nop();
    ALUResultM = '0; WriteDataM = '0; MemWriteM = 1'b0; ResultSrcM = 2'b00;
    RegWriteM  = 1'b0; RdM = '0; PCPlus4M = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive_nop();
    req_ready = 1'b0; resp_valid = 1'b0; resp_rdata = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // Non-memory op; call at posedge+1. Result reaches W on the next edge.
  task automatic run_alu(input logic [XLEN-1:0] alu, input logic [XLEN-1:0] pc4,
                         input logic [1:0] src, input logic [4:0] rd, input logic rw,
                         input string tag);
    logic [XLEN-1:0] exp_res;
    exp_res = (src == 2'b10) ? pc4 : alu;
    ALUResultM = alu; PCPlus4M = pc4; ResultSrcM = src; RdM = rd; RegWriteM = rw;
    MemWriteM = 1'b0; WriteDataM = $urandom;
    @(negedge clk);
    assert_cnt++;
    if (StallM !== 1'b0) begin
      fail_cnt++; $display("FAIL %s_stall: got %b exp 0", tag, StallM);
    end
    @(posedge clk); #1;
    assert_cnt++;
    if ({ResultW, RdW, RegWriteW} !== {exp_res, rd, rw}) begin
      fail_cnt++;
      $display("FAIL %s_w: got res=%h rd=%0d we=%b exp res=%h rd=%0d we=%b",
               tag, ResultW, RdW, RegWriteW, exp_res, rd, rw);
    end
  endtask

  // Memory op; call at posedge+1. Plays the bus with the given ready and
  // response delays, checks payload, stall length and writeback.
  task automatic run_mem_op(input logic [XLEN-1:0] addr, input logic [XLEN-1:0] wdata,
                            input logic [XLEN-1:0] rdata, input logic is_store,
                            input logic rw, input logic [4:0] rd,
                            input int rdy_dly, input int rsp_dly, input string tag);
    bit mis;
    int exp_stall, exp_reqc;
    int stall_cnt, req_cnt, bubble_bad, req_wait, resp_wait;
    bit in_resp, hs_now, got_resp, done;
    mis       = ALIGN_EN && (addr[1:0] != 2'b00);
    exp_stall = mis ? 1 : (is_store ? rdy_dly + 2 : rdy_dly + rsp_dly + 3);
    exp_reqc  = mis ? 0 : rdy_dly + 1;
    stall_cnt = 0; req_cnt = 0; bubble_bad = 0; req_wait = 0; resp_wait = 0;
    in_resp = 0; hs_now = 0; got_resp = 0; done = 0;
    if (!mis) exp_q.push_back(is_store ? addr : rdata);

    ALUResultM = addr; WriteDataM = wdata; MemWriteM = is_store;
    ResultSrcM = is_store ? 2'b00 : 2'b01; RegWriteM = rw; RdM = rd;
    PCPlus4M = $urandom;

    for (int c = 0; c < 60 && !done; c++) begin
      @(negedge clk);
      if (req_valid) begin
        assert_cnt++;
        if ({req_we, req_addr, req_wdata} !== {is_store, addr & ~32'd3, wdata}) begin
          fail_cnt++;
          $display("FAIL %s_payload: got we=%b addr=%h wd=%h exp we=%b addr=%h wd=%h",
                   tag, req_we, req_addr, req_wdata, is_store, addr & ~32'd3, wdata);
        end
        req_ready = (req_wait >= rdy_dly);
        hs_now    = req_ready;
        req_wait++;
        req_cnt++;
      end else begin
        req_ready = 1'($urandom_range(0, 1));
      end
      if (in_resp) begin
        resp_valid = (resp_wait == rsp_dly);
        resp_rdata = (resp_wait == rsp_dly) ? rdata : $urandom;
        got_resp   = (resp_wait == rsp_dly);
        resp_wait++;
      end else begin
        resp_valid = 1'($urandom_range(0, 1));
        resp_rdata = $urandom;
      end
      #1;
      if (StallM) begin
        stall_cnt++;
        if (c >= 1 && RegWriteW !== 1'b0) bubble_bad++;
      end else begin
        done = 1;
      end
      if (!done) begin
        @(posedge clk);
        if (hs_now && !is_store) in_resp = 1;
        if (got_resp) in_resp = 0;
        hs_now = 0; got_resp = 0;
      end
    end

    assert_cnt++;
    if (!done) begin
      fail_cnt++;
      $display("FAIL %s_timeout: StallM still %b after 60 cycles exp 0", tag, StallM);
    end else begin
      @(posedge clk); #1;
      assert_cnt++;
      if (stall_cnt != exp_stall) begin
        fail_cnt++; $display("FAIL %s_stall_len: got %0d exp %0d", tag, stall_cnt, exp_stall);
      end
      assert_cnt++;
      if (req_cnt != exp_reqc) begin
        fail_cnt++; $display("FAIL %s_req_cycles: got %0d exp %0d", tag, req_cnt, exp_reqc);
      end
      assert_cnt++;
      if (bubble_bad != 0) begin
        fail_cnt++; $display("FAIL %s_bubble: got %0d stalled cycles with RegWriteW=1 exp 0", tag, bubble_bad);
      end
      assert_cnt++;
      if ({RdW, RegWriteW, MisalignW} !== {rd, rw & ~mis, mis}) begin
        fail_cnt++;
        $display("FAIL %s_wctl: got rd=%0d we=%b mis=%b exp rd=%0d we=%b mis=%b",
                 tag, RdW, RegWriteW, MisalignW, rd, rw & ~mis, mis);
      end
      if (!mis) begin
        logic [XLEN-1:0] exp_res;
        exp_res = exp_q.pop_front();
        assert_cnt++;
        if (ResultW !== exp_res) begin
          fail_cnt++; $display("FAIL %s_result: got %h exp %h", tag, ResultW, exp_res);
        end
      end
    end
  endtask

  // after an op, a nop must leave W disabled and MisalignW low
  task automatic check_nop_follow(input string tag);
    drive_nop();
    @(posedge clk); #1;
    assert_cnt++;
    if ({RegWriteW, MisalignW} !== 2'b00) begin
      fail_cnt++;
      $display("FAIL %s_follow: got we=%b mis=%b exp 0 0", tag, RegWriteW, MisalignW);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    do_reset();
    assert_cnt++;
    if ({ResultW, RdW, RegWriteW, MisalignW} !== '0) begin
      fail_cnt++;
      $display("FAIL reset_w: got res=%h rd=%0d we=%b mis=%b exp all 0", ResultW, RdW, RegWriteW, MisalignW);
    end
    assert_cnt++;
    if ({req_valid, req_we, req_addr, req_wdata} !== '0) begin
      fail_cnt++;
      $display("FAIL reset_bus: got v=%b we=%b addr=%h wd=%h exp all 0", req_valid, req_we, req_addr, req_wdata);
    end
    assert_cnt++;
    if (dbg_state !== ST_IDLE) begin
      fail_cnt++; $display("FAIL reset_state: got %0d exp %0d", dbg_state, ST_IDLE);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      assert_cnt++;
      if (StallM !== 1'b0) begin
        fail_cnt++; $display("FAIL reset_idle_stall: got %b exp 0", StallM);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_alu();
    logic [1:0] srcs [3];
    srcs[0] = 2'b00; srcs[1] = 2'b10; srcs[2] = 2'b11;
    run_alu(32'h0000_0010, 32'h0, 2'b00, 5'd5, 1'b1, "alu_add");
    for (int i = 0; i < 8; i++)
      run_alu($urandom, $urandom, srcs[$urandom_range(0, 2)], 5'($urandom),
              1'($urandom_range(0, 1)), "alu_rand");
  endtask

  task automatic test_jal();
    run_alu($urandom, 32'h0000_0048, 2'b10, 5'd1, 1'b1, "jal");
  endtask

  task automatic test_store();
    run_mem_op(32'h0000_0100, 32'hDEAD_BEEF, 32'h0, 1'b1, 1'b0, 5'd0, 0, 0, "store");
    check_nop_follow("store");
  endtask

  task automatic test_load();
    run_mem_op(32'h0000_0204, 32'h0, 32'h1234_5678, 1'b0, 1'b1, 5'd7, 2, 2, "load");
    check_nop_follow("load");
  endtask

  task automatic test_misalign();
    run_mem_op(32'h0000_0103, 32'h0, 32'hA5A5_0103, 1'b0, 1'b1, 5'd3, 0, 0, "misalign");
    check_nop_follow("misalign");
  endtask

  task automatic test_back_to_back();
    run_mem_op(32'h0000_0040, 32'h0BAD_CAFE, 32'h0, 1'b1, 1'b0, 5'd0, 1, 0, "b2b_st");
    run_mem_op(32'h0000_0044, 32'h0, 32'h7777_1111, 1'b0, 1'b1, 5'd9, 0, 1, "b2b_ld0");
    run_mem_op(32'h0000_0048, 32'h0, 32'h3333_2222, 1'b0, 1'b1, 5'd10, 0, 0, "b2b_ld1");
    check_nop_follow("b2b");
  endtask

  task automatic test_random_mem();
    for (int i = 0; i < 14; i++) begin
      logic st;
      st = 1'($urandom_range(0, 1));
      run_mem_op($urandom, $urandom, $urandom, st, ~st, 5'($urandom_range(1, 31)),
                 $urandom_range(0, 3), $urandom_range(0, 3), "rand_mem");
      if ($urandom_range(0, 1) == 1) begin
        drive_nop();
        @(posedge clk); #1;
      end
    end
    check_nop_follow("rand_mem");
  endtask

  task automatic test_reset_mid();
    ALUResultM = 32'h0000_0300; WriteDataM = '0; MemWriteM = 1'b0;
    ResultSrcM = 2'b01; RegWriteM = 1'b1; RdM = 5'd9; PCPlus4M = '0;
    @(negedge clk); req_ready = 1'b0; resp_valid = 1'b0;
    @(posedge clk);
    @(negedge clk); req_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_ready = 1'b0;
    assert_cnt++;
    if (dbg_state !== ST_RESP) begin
      fail_cnt++; $display("FAIL rmid_in_resp: got %0d exp %0d", dbg_state, ST_RESP);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    drive_nop();
    assert_cnt++;
    if ({dbg_state, req_valid, RegWriteW} !== {ST_IDLE, 1'b0, 1'b0}) begin
      fail_cnt++;
      $display("FAIL rmid_after_reset: got st=%0d v=%b we=%b exp st=0 v=0 we=0", dbg_state, req_valid, RegWriteW);
    end
    @(negedge clk);
    resp_valid = 1'b1; resp_rdata = 32'hCAFE_F00D;
    @(posedge clk); #1;
    resp_valid = 1'b0;
    @(posedge clk); #1;
    assert_cnt++;
    if ({dbg_state, RegWriteW, ResultW} !== {ST_IDLE, 1'b0, 32'h0}) begin
      fail_cnt++;
      $display("FAIL rmid_ignored_resp: got st=%0d we=%b res=%h exp st=0 we=0 res=0", dbg_state, RegWriteW, ResultW);
    end
    // the abandoned load must not poison the next one
    run_mem_op(32'h0000_0304, 32'h0, 32'h0101_0202, 1'b0, 1'b1, 5'd11, 0, 0, "rmid_next");
    check_nop_follow("rmid");
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_alu();
    test_jal();
    test_store();
    test_load();
    test_misalign();
    test_back_to_back();
    test_random_mem();
    test_reset_mid();
    assert_cnt++;
    if (exp_q.size() != 0) begin
      fail_cnt++; $display("FAIL scoreboard_drain: got %0d entries left exp 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule
